// File: rtl/skew_inbuf_bank.sv
// skew_inbuf_bank: NCH-lane circular FIFO bank feeding skewed operand streams to the PE array edge.
// Optional macro SKEW_PAD_EN: when defined, lane i starts with i zero pads; otherwise lanes stay aligned.
module skew_inbuf_bank #(
  parameter int WORDLEN = 8,
  parameter int DEPTH   = 16,
  parameter int NCH     = 4
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             flush,
  input  logic                             write,
  input  logic [NCH*WORDLEN-1:0]           din,
  input  logic                             read,
  output logic [NCH*WORDLEN-1:0]           dout,
  output logic [NCH-1:0]                   lane_valid,
  output logic                             full,
  output logic                             empty,
  output logic [NCH*$clog2(DEPTH+1)-1:0]   count,
  output logic                             ovf,
  output logic                             unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
`ifdef SKEW_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic [WORDLEN-1:0] r_mem  [NCH][DEPTH];
  logic [PW-1:0]      r_head [NCH];
  logic [PW-1:0]      r_tail [NCH];
  logic [CW-1:0]      r_cnt  [NCH];
  logic [PW-1:0]      r_pad  [NCH];
  logic               r_ovf;
  logic               r_unf;

  logic               w_full;
  logic               w_empty;
  logic               w_wr_en;
  logic               w_rd_en;
  logic [NCH-1:0]     w_head_data;
  logic [NCH-1:0]     w_rd_data;

  // Pad count never exceeds NCH-1 <= DEPTH-1, so it fits in a pointer-width counter.
  function automatic logic [PW-1:0] pad_init(input int lane);
    return PAD_EN ? PW'(lane) : {PW{1'b0}};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Bank-level full/empty from the pre-edge lane counts.
  always_comb begin
    w_full  = 1'b0;
    w_empty = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      w_full  = w_full | (r_cnt[i] == CW'(DEPTH));
      w_empty = w_empty & (r_cnt[i] == {CW{1'b0}});
    end
  end

  assign w_wr_en   = write & ~w_full;
  assign w_rd_en   = read & ~w_empty;
  assign w_rd_data = {NCH{w_rd_en}} & w_head_data;

  // Per-lane head decode: a lane shows data only once its pads are used up.
  always_comb begin
    dout       = {(NCH*WORDLEN){1'b0}};
    lane_valid = {NCH{1'b0}};
    count      = {(NCH*CW){1'b0}};
    for (int i = 0; i < NCH; i++) begin
      w_head_data[i]               = (r_pad[i] == {PW{1'b0}}) && (r_cnt[i] != {CW{1'b0}});
      dout[i*WORDLEN +: WORDLEN]   = w_head_data[i] ? r_mem[i][r_head[i]] : {WORDLEN{1'b0}};
      lane_valid[i]                = (r_pad[i] != {PW{1'b0}}) || (r_cnt[i] != {CW{1'b0}});
      count[i*CW +: CW]            = r_cnt[i];
    end
  end

  assign full  = w_full;
  assign empty = w_empty;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

  // Pointer, occupancy, pad and sticky-flag state; flush reloads the reset image.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_head[i] <= {PW{1'b0}};
        r_tail[i] <= {PW{1'b0}};
        r_cnt[i]  <= {CW{1'b0}};
        r_pad[i]  <= pad_init(i);
      end
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NCH; i++) begin
        r_head[i] <= {PW{1'b0}};
        r_tail[i] <= {PW{1'b0}};
        r_cnt[i]  <= {CW{1'b0}};
        r_pad[i]  <= pad_init(i);
      end
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_wr_en) r_tail[i] <= ptr_inc(r_tail[i]);
        else         r_tail[i] <= r_tail[i];
        if (w_rd_data[i]) r_head[i] <= ptr_inc(r_head[i]);
        else              r_head[i] <= r_head[i];
        if (w_rd_en && (r_pad[i] != {PW{1'b0}})) r_pad[i] <= r_pad[i] - PW'(1);
        else                                     r_pad[i] <= r_pad[i];
        r_cnt[i] <= r_cnt[i] + CW'(w_wr_en) - CW'(w_rd_data[i]);
      end
      r_ovf <= r_ovf | (write & w_full);
      r_unf <= r_unf | (read & w_empty);
    end
  end

  // Lane storage is deliberately left unreset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_wr_en && !flush) begin
      for (int i = 0; i < NCH; i++) begin
        r_mem[i][r_tail[i]] <= din[i*WORDLEN +: WORDLEN];
      end
    end
  end

endmodule
